// File: rtl/stepdown_pkg.sv
// Shared definitions for the stepdown core-state sequencer.
// Provides the state encoding (also exported as the debug state bus),
// the default soft-start width, a ramp full-scale helper and state-class helpers.
package stepdown_pkg;

  localparam int unsigned SS_W_DEF = 6;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_SOFTSTART = 3'd1,
    ST_REGULATE  = 3'd2,
    ST_FAULT     = 3'd3,
    ST_COOLDOWN  = 3'd4,
    ST_LATCHED   = 3'd5
  } sd_state_e;

  // Ramp full-scale code for a given soft-start width.
  function automatic int unsigned ss_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // States in which the power stage is switching.
  function automatic logic is_driving(input sd_state_e s);
    return (s == ST_SOFTSTART) || (s == ST_REGULATE);
  endfunction

  // States reported on the fault pin.
  function automatic logic is_fault(input sd_state_e s);
    return (s == ST_FAULT) || (s == ST_COOLDOWN) || (s == ST_LATCHED);
  endfunction

endpackage

// File: rtl/sd_debounce.sv
// Consecutive-high run detector.
// Counts back-to-back cycles with din high; any low cycle or clr empties the count.
// done_c is combinational: high on the N-th (and every later) consecutive high cycle.
// Ports: clk, rst_n (async active-low), clr (hold count at zero), din, done_c.
module sd_debounce #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic din,
  output logic done_c
);

  localparam int unsigned CW = $clog2(N + 1);

  logic [CW-1:0] cnt_q;

  // Run-length counter, saturating at N.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || !din) begin
      cnt_q <= '0;
    end else if (cnt_q != CW'(N)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // This cycle completes the run if N-1 highs are already banked.
  assign done_c = !clr && din && (cnt_q >= CW'(N - 1));

endmodule

// File: rtl/stepdown_corestate_seq.sv
// Core-state sequencer for the stepdown regulator.
// Owns enable, soft-start ramp, OCP/OTP hiccup retry with latch-off, and power-good.
// Ports:
//   CELCLK, CELRSTN        clock, async active-low reset
//   CELV, CELG, SUB        supply/ground/substrate pins, no function
//   test_mode              1 = one ramp step per cycle, 4-cycle cooldown
//   en, uvlo_ok, ocp, otp, pg_ok   async inputs, 2-flop synchronised
//   ss_code                reference-DAC ramp code
//   drv_en, pgood, fault   power-stage enable, debounced power-good, fault flag
//   state                  current state encoding (debug)
module stepdown_corestate_seq
  import stepdown_pkg::*;
#(
  parameter int unsigned SS_W      = SS_W_DEF,
  parameter int unsigned SS_DIV    = 16,
  parameter int unsigned OCP_DEB   = 4,
  parameter int unsigned PG_DEB    = 8,
  parameter int unsigned COOL_CYC  = 1024,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic            CELCLK,
  input  logic            CELRSTN,
  input  logic            CELV,
  input  logic            CELG,
  input  logic            SUB,
  input  logic            test_mode,
  input  logic            en,
  input  logic            uvlo_ok,
  input  logic            ocp,
  input  logic            otp,
  input  logic            pg_ok,
  output logic [SS_W-1:0] ss_code,
  output logic            drv_en,
  output logic            pgood,
  output logic            fault,
  output logic [2:0]      state
);

  localparam int unsigned STEP_W  = (SS_DIV > 1) ? $clog2(SS_DIV) : 1;
  localparam int unsigned COOL_W  = $clog2(COOL_CYC);
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [SS_W-1:0]    SS_PENULT = SS_W'(ss_max(SS_W) - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  // Pad pins carry no logic; folded into a sink so they stay connected.
  logic unused_pins;
  assign unused_pins = ^{CELV, CELG, SUB};

  // Two-flop synchronisers for the asynchronous control pins.
  logic [4:0] sync1_q, sync2_q;
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {en, uvlo_ok, ocp, otp, pg_ok};
      sync2_q <= sync1_q;
    end
  end

  logic en_s, uvlo_s, ocp_s, otp_s, pg_s, run_ok;
  assign {en_s, uvlo_s, ocp_s, otp_s, pg_s} = sync2_q;
  assign run_ok = en_s && uvlo_s;

  sd_state_e          state_q, state_n;
  logic [STEP_W-1:0]  step_q, step_n;
  logic [SS_W-1:0]    code_q, code_n;
  logic [COOL_W-1:0]  cool_q, cool_n;
  logic [RETRY_W-1:0] retry_q, retry_n;
  logic               drv_en_q, drv_en_n;
  logic               pgood_q, pgood_n;
  logic               fault_q, fault_n;

  // Overcurrent is only watched while switching; power-good only in regulation.
  logic ocp_clr, pg_clr, ocp_hit_c, pg_hit_c;
  assign ocp_clr = !is_driving(state_q);
  assign pg_clr  = (state_q != ST_REGULATE);

  sd_debounce #(.N(OCP_DEB)) u_ocp_deb (
    .clk    (CELCLK),
    .rst_n  (CELRSTN),
    .clr    (ocp_clr),
    .din    (ocp_s),
    .done_c (ocp_hit_c)
  );

  sd_debounce #(.N(PG_DEB)) u_pg_deb (
    .clk    (CELCLK),
    .rst_n  (CELRSTN),
    .clr    (pg_clr),
    .din    (pg_s),
    .done_c (pg_hit_c)
  );

  // test_mode shortens the ramp divider and the cooldown for ATE.
  logic [STEP_W-1:0] step_last;
  logic [COOL_W-1:0] cool_last;
  assign step_last = test_mode ? '0 : STEP_W'(SS_DIV - 1);
  assign cool_last = test_mode ? COOL_W'(3) : COOL_W'(COOL_CYC - 1);

  // Next-state, counters and next registered outputs.
  always_comb begin
    state_n = state_q;
    step_n  = step_q;
    code_n  = code_q;
    cool_n  = cool_q;
    retry_n = retry_q;

    case (state_q)
      ST_OFF: begin
        if (run_ok) state_n = ST_SOFTSTART;
      end
      ST_SOFTSTART, ST_REGULATE: begin
        // otp beats enable loss beats overcurrent beats ramp progress.
        if (otp_s) begin
          state_n = ST_FAULT;
        end else if (!run_ok) begin
          state_n = ST_OFF;
        end else if (ocp_hit_c) begin
          state_n = ST_FAULT;
        end else if (state_q == ST_SOFTSTART) begin
          if (step_q == step_last) begin
            step_n = '0;
            code_n = code_q + 1'b1;
            if (code_q == SS_PENULT) state_n = ST_REGULATE;
          end else begin
            step_n = step_q + 1'b1;
          end
        end
      end
      ST_FAULT: begin
        state_n = ST_COOLDOWN;
        cool_n  = '0;
      end
      ST_COOLDOWN: begin
        if (otp_s) begin
          cool_n = '0;
        end else if (!run_ok) begin
          state_n = ST_OFF;
        end else if (cool_q == cool_last) begin
          state_n = (retry_q == RETRY_MAX) ? ST_LATCHED : ST_SOFTSTART;
          cool_n  = '0;
        end else begin
          cool_n = cool_q + 1'b1;
        end
      end
      ST_LATCHED: begin
        if (!en_s) state_n = ST_OFF;
      end
      default: begin
        state_n = ST_OFF;
      end
    endcase

    // Ramp restarts from zero whenever the stage stops switching.
    if (!is_driving(state_n)) begin
      step_n = '0;
      code_n = '0;
    end

    // Retry budget refills only once the enable pin has been dropped.
    if (!en_s) begin
      retry_n = '0;
    end else if ((state_n == ST_FAULT) && (state_q != ST_FAULT) && (retry_q != RETRY_MAX)) begin
      retry_n = retry_q + 1'b1;
    end

    drv_en_n = is_driving(state_n);
    fault_n  = is_fault(state_n);
    pgood_n  = (state_n == ST_REGULATE) && pg_hit_c;
  end

  // State, counters and outputs register.
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      state_q  <= ST_OFF;
      step_q   <= '0;
      code_q   <= '0;
      cool_q   <= '0;
      retry_q  <= '0;
      drv_en_q <= 1'b0;
      pgood_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      step_q   <= step_n;
      code_q   <= code_n;
      cool_q   <= cool_n;
      retry_q  <= retry_n;
      drv_en_q <= drv_en_n;
      pgood_q  <= pgood_n;
      fault_q  <= fault_n;
    end
  end

  assign ss_code = code_q;
  assign drv_en  = drv_en_q;
  assign pgood   = pgood_q;
  assign fault   = fault_q;
  assign state   = state_q;

endmodule
